palindrome_tx: RTL
==================

# palindrome_tx

Serial transmitter that generates palindromic bit frames for the serial palindrome-checking path. It accepts a half-word on a valid/ready input and shifts out the half-word MSB-first, then its mirror, one bit per cycle. Every emitted frame reads the same forwards and backwards, so downstream serial palindrome detectors can be driven with known-good traffic. It sits between a parallel stimulus or control source and the single-bit serial line `x`.

## Interface
- `HALF_W`, default 4: half-frame width in bits; legal range 2..16.
- `ODD`, default 1:
  - 1: centre bit sent once; frame length L = 2*HALF_W-1.
  - 0: centre bit duplicated; L = 2*HALF_W.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `data_i` input HALF_W: half-word to transmit; sampled only on accept.
- `valid_i` input 1: `data_i` is valid.
- `ready_o` output 1: block can accept a half-word this cycle.
- `x_o` output 1: serial data bit.
- `x_valid_o` output 1: `x_o` carries a frame bit this cycle.
- `sof_o` output 1: first bit of a frame is on `x_o`.
- `eof_o` output 1: last bit of a frame is on `x_o`.
- `busy_o` output 1: a frame is in flight.

## Operation
- **States:**
  - IDLE: nothing in flight.
  - FWD: sending `data[HALF_W-1]` down to `data[0]`.
  - REV: sending the mirror.
- **Accept:** an accept occurs when `valid_i & ready_o` is true at a rising edge. On accept, `data_i` is captured into the hold register, the bit index is cleared, and the state moves to FWD.
- **`ready_o` (combinational):**
  - 1 in IDLE.
  - 1 in the cycle where `eof_o`=1.
  - 0 otherwise, and 0 while `reset` is high.
- **FWD:** bit i of the frame (i = 0..HALF_W-1) is `data[HALF_W-1-i]`. After bit HALF_W-1, the state moves to REV.
- **REV, ODD=1:** sends `data[1]`, `data[2]`, …, `data[HALF_W-1]` (HALF_W-1 bits).
- **REV, ODD=0:** sends `data[0]`, …, `data[HALF_W-1]` (HALF_W bits).
- **Frame end:** after the last REV bit, the state goes to IDLE. If an accept occurs in the `eof_o` cycle, the state goes directly to FWD with the new data.
- **Frame bit index:**
  - Width is `$clog2(2*HALF_W)`.
  - Counts 0..L-1 and never wraps past L-1; it is reset to 0 on each accept.
  - The last bit is at index L-1.
- **Outputs in IDLE:** `valid_i` is ignored whenever `ready_o`=0; `data_i` changes mid-frame have no effect. In IDLE, `x_o`=0 and `x_valid_o`=`sof_o`=`eof_o`=0.
- **Output registers:** `busy_o`, `x_o`, `x_valid_o`, `sof_o` and `eof_o` are all registered.
  - `busy_o` = (state != IDLE).
  - `sof_o` is 1 only for bit index 0.
  - `eof_o` is 1 only for index L-1.
- **Reset:**
  - Reset is asynchronous and takes effect immediately: state IDLE, index 0, hold register 0.
  - `x_o`, `x_valid_o`, `sof_o`, `eof_o` and `busy_o` all go to 0.
  - Reset mid-frame aborts the frame. No `eof_o` is emitted, and the first cycle after reset release is IDLE with `ready_o`=1.

## Timing
- **Latency:** an accept at edge E puts frame bit 0 on `x_o` (with `sof_o`=1 and `x_valid_o`=1) in the cycle following E. Bit i appears in cycle E+1+i.
- **Throughput:** one bit per cycle; a frame spans exactly L consecutive cycles with `x_valid_o`=1.
- **Back-to-back frames:** an accept during the `eof_o` cycle makes the next frame's `sof_o` the immediately following cycle, with zero gap.
- **Gap:** without that accept, `x_valid_o` drops to 0 the cycle after `eof_o`.
- **Minimum-length frame:** for HALF_W=2, ODD=1, L=3, so `sof_o` and `eof_o` are two cycles apart. `sof_o` and `eof_o` are never high in the same cycle, because L≥3.
- **Control path:** there is no combinational path from `valid_i` or `data_i` to any output except `ready_o`, which does not depend on `valid_i`.

## Structure
- **Shared package `palindrome_pkg`:**
  - enum `tx_state_e` {IDLE, FWD, REV};
  - function `frame_len(half_w, odd)` returning 2*half_w-odd;
  - constant `PAL_MAX_HALF_W` = 16.
- **Module body:** a single module with no sub-module. Datapath is the hold register plus an index-selected mux; control is the 3-state FSM plus the index counter.
- **Elaboration checks:** assert 2 ≤ HALF_W ≤ PAL_MAX_HALF_W and ODD ∈ {0,1}.

## Test plan
- **Minimum odd frame:** HALF_W=2, ODD=1, `data_i`=2'b10, single accept → `x_o` = 1,0,1. `sof_o` is on the first bit, `eof_o` on the third, and a 3-bit palindrome detector on the line asserts on the third bit.
- **Even frame:** HALF_W=4, ODD=0, `data_i`=4'b1101 → `x_o` = 1,1,0,1,1,0,1,1 over 8 cycles. `x_valid_o`=0 in the cycle after.
- **Back-to-back:** HALF_W=4, ODD=1, 4'b1000 then 4'b0110, with `valid_i` held high → 1,0,0,0,0,0,1 immediately followed by 0,1,1,0,1,1,0. The second `sof_o` is the cycle after the first `eof_o`, and `ready_o` is high only in IDLE/`eof_o` cycles.
- **Ignored input:** while `busy_o`=1 and `ready_o`=0, toggle `data_i` and hold `valid_i`=1 → the in-flight bits are unchanged and no extra frame starts until the `eof_o` cycle.
- **Reset mid-frame:** assert `reset` at bit index 2 → all outputs are 0 immediately and no `eof_o` is emitted. After release, `ready_o`=1, and a new accept of 4'b1111 yields seven 1s with correct `sof_o`/`eof_o`.
- **Idle hold:** `valid_i`=0 for 20 cycles after reset → `x_valid_o`=0, `busy_o`=0 and `ready_o`=1 throughout.

Source files
------------

// File: rtl/palindrome_pkg.sv
`default_nettype none
// ============================================================================
// Package     : palindrome_pkg
// Description : Shared types and helpers for the serial palindrome path.
// Revision    : 1.0 - initial release
// ============================================================================
package palindrome_pkg;

  // Largest supported half-frame width.
  localparam int PAL_MAX_HALF_W = 16;

  // Transmitter state: idle, forward half, mirrored half.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } tx_state_e;

  // Frame length: odd frames share the centre bit between both halves.
  function automatic int frame_len(input int half_w, input int odd);
    return 2 * half_w - odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/palindrome_tx_if.sv
`default_nettype none
// ============================================================================
// Interface   : palindrome_tx_if
// Description : Half-word valid/ready input and serial frame output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface palindrome_tx_if #(
  parameter int HALF_W = 4
) ();

  logic [HALF_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic              x_o;
  logic              x_valid_o;
  logic              sof_o;
  logic              eof_o;
  logic              busy_o;

  // Stimulus/control source side.
  modport master (
    output data_i, valid_i,
    input  ready_o, x_o, x_valid_o, sof_o, eof_o, busy_o
  );

  // Transmitter side.
  modport slave (
    input  data_i, valid_i,
    output ready_o, x_o, x_valid_o, sof_o, eof_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/palindrome_tx.sv
`default_nettype none
// ============================================================================
// Module      : palindrome_tx
// Description : Serial transmitter emitting a half-word MSB-first followed by
//               its mirror, producing a palindromic bit frame.
// Revision    : 1.0 - initial release
// ============================================================================
module palindrome_tx
  import palindrome_pkg::*;
#(
  parameter int HALF_W = 4,
  parameter int ODD    = 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  palindrome_tx_if.slave   bus
);

  localparam int c_frame_len = frame_len(HALF_W, ODD);
  localparam int IDX_W       = $clog2(2 * HALF_W);

  // Reject unsupported widths and centre modes at elaboration.
  generate
    if (HALF_W < 2 || HALF_W > PAL_MAX_HALF_W || (ODD != 0 && ODD != 1)) begin : g_param_check
      $error("palindrome_tx: HALF_W must be 2..16 and ODD must be 0 or 1");
    end
  endgenerate

  tx_state_e          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HALF_W-1:0]  hold_q, hold_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               sof_q, sof_d;
  logic               eof_q, eof_d;
  logic               busy_q, busy_d;

  logic               w_ready;
  logic               w_accept;
  logic [IDX_W-1:0]   w_sel;
  logic [HALF_W-1:0]  w_word;

  // New data may enter when idle or when the last bit is on the line.
  assign w_ready  = ~reset & ((state_q == IDLE) | eof_q);
  assign w_accept = bus.valid_i & w_ready;

  // Next state, bit index and hold register; output bits derive from the
  // next state so that the registered outputs line up with the frame index.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    w_sel     = '0;
    w_word    = '0;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    busy_d    = 1'b0;

    if (w_accept) begin
      hold_d  = bus.data_i;
      idx_d   = '0;
      state_d = FWD;
    end else begin
      unique case (state_q)
        FWD: begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(HALF_W - 1)) state_d = REV;
        end
        REV: begin
          // The index parks at the last bit rather than wrapping.
          if (idx_q == IDX_W'(c_frame_len - 1)) state_d = IDLE;
          else                                  idx_d   = idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end

    // Forward half walks down from the MSB; mirror half walks back up,
    // skipping bit 0 when the centre bit is shared.
    if (idx_d < IDX_W'(HALF_W)) w_sel = IDX_W'(HALF_W - 1) - idx_d;
    else                        w_sel = idx_d - IDX_W'(HALF_W - ODD);
    w_word = hold_d >> w_sel;

    busy_d    = (state_d != IDLE);
    x_valid_d = busy_d;
    x_d       = busy_d & w_word[0];
    sof_d     = busy_d & (idx_d == '0);
    eof_d     = busy_d & (idx_d == IDX_W'(c_frame_len - 1));
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      hold_q    <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ready_o   = w_ready;
  assign bus.x_o       = x_q;
  assign bus.x_valid_o = x_valid_q;
  assign bus.sof_o     = sof_q;
  assign bus.eof_o     = eof_q;
  assign bus.busy_o    = busy_q;

endmodule
`default_nettype wire
